// File: rtl/alu_multicycle_unit.sv
// alu_multicycle_unit: ALU with single-cycle ops and iterative one-bit-per-clock shifts
module alu_multicycle_unit #(
  parameter int WIDTH  = 32,
  parameter int PC_INC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic [WIDTH-1:0] result_o,
  output logic             branch_taken_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
    OP_OR = 4'b0011, OP_XOR = 4'b0100, OP_LUI = 4'b0101, OP_SRL = 4'b0110,
    OP_SLL = 4'b0111, OP_BEQ = 4'b1000, OP_BNE = 4'b1010, OP_BLT = 4'b1011,
    OP_BGE = 4'b1100, OP_JAL = 4'b1101;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, result_q, result_d, alu_res, sh_next;
  logic [SW-1:0]    cnt_q, cnt_d, amt;
  logic             sll_q, sll_d, branch_q, branch_d, done_q, done_d, alu_br, is_shift;
  assign amt            = B_i[SW-1:0];
  assign is_shift       = (ALU_Operation_i == OP_SRL) || (ALU_Operation_i == OP_SLL);
  assign sh_next        = sll_q ? shreg_q << 1 : shreg_q >> 1;
  assign result_o       = result_q;
  assign branch_taken_o = branch_q;
  assign busy_o         = (state_q == SHIFT);
  assign done_o         = done_q;
  // single-cycle datapath; a zero-amount shift passes A through unchanged
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (ALU_Operation_i)
      OP_ADD:         alu_res = A_i + B_i;
      OP_SUB:         alu_res = A_i - B_i;
      OP_AND:         alu_res = A_i & B_i;
      OP_OR:          alu_res = A_i | B_i;
      OP_XOR:         alu_res = A_i ^ B_i;
      OP_LUI:         alu_res = B_i;
      OP_SRL, OP_SLL: alu_res = A_i;
      OP_BEQ:         alu_br  = (A_i == B_i);
      OP_BNE:         alu_br  = (A_i != B_i);
      OP_BLT:         alu_br  = ($signed(A_i) < $signed(B_i));
      OP_BGE:         alu_br  = ($signed(A_i) >= $signed(B_i));
      OP_JAL:         alu_res = A_i + WIDTH'(PC_INC);
      default:        alu_res = '0;
    endcase
  end
  // next-state: accept in IDLE, shift one bit per clock in SHIFT, publish on the last bit
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sll_d    = sll_q;
    result_d = result_q;
    branch_d = branch_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (start_i && is_shift && amt != '0) begin
        shreg_d = A_i;
        cnt_d   = amt;
        sll_d   = ALU_Operation_i[0];
        state_d = SHIFT;
      end else if (start_i) begin
        result_d = alu_res;
        branch_d = alu_br;
        done_d   = 1'b1;
      end
    end else begin
      shreg_d = sh_next;
      cnt_d   = cnt_q - SW'(1);
      if (cnt_q == SW'(1)) begin
        result_d = sh_next;
        branch_d = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
    end
  end
  // state and registered outputs; reset discards any in-flight shift
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sll_q    <= 1'b0;
      result_q <= '0;
      branch_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sll_q    <= sll_d;
      result_q <= result_d;
      branch_q <= branch_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_alu_multicycle_unit.sv
// tb_alu_multicycle_unit: randomized and directed checks against a behavioural ALU model
module tb_alu_multicycle_unit;
  logic        clk = 1'b0, reset = 1'b0, start_i = 1'b0;
  logic [3:0]  ALU_Operation_i = '0;
  logic [31:0] A_i = '0, B_i = '0, result_o;
  logic        branch_taken_o, busy_o, done_o;
  int          n_checks = 0, n_err = 0;

  alu_multicycle_unit #(.WIDTH(32), .PC_INC(4)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .ALU_Operation_i(ALU_Operation_i),
    .A_i(A_i), .B_i(B_i), .result_o(result_o), .branch_taken_o(branch_taken_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // {branch, result} from the op map with plain arithmetic
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return {1'b0, a + b};
      4'd1:    return {1'b0, a - b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return {1'b0, b};
      4'd6:    return {1'b0, a >> b[4:0]};
      4'd7:    return {1'b0, a << b[4:0]};
      4'd8:    return {a == b, 32'd0};
      4'd10:   return {a != b, 32'd0};
      4'd11:   return {$signed(a) < $signed(b), 32'd0};
      4'd12:   return {$signed(a) >= $signed(b), 32'd0};
      4'd13:   return {1'b0, a + 32'd4};
      default: return 33'd0;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [31:0] b);
    return ((op == 4'd6 || op == 4'd7) && b[4:0] != 0) ? int'(b[4:0]) + 1 : 1;
  endfunction

  // issue one op, scramble inputs after accept, wait for done and check everything
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [32:0] m;
    int          lat, busy_cnt, exp_lat;
    m        = model(op, a, b);
    exp_lat  = latency(op, b);
    lat      = 1;
    busy_cnt = 0;
    @(negedge clk);
    start_i = 1'b1; ALU_Operation_i = op; A_i = a; B_i = b;
    @(posedge clk);
    #1;
    start_i = 1'b0; ALU_Operation_i = 4'($urandom); A_i = $urandom; B_i = $urandom;
    while (!done_o && lat < 100) begin
      if (busy_o) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result_o, m[31:0]);
    check({tag, " branch"}, {31'd0, branch_taken_o}, {31'd0, m[32]});
    check({tag, " busy cycles"}, busy_cnt, exp_lat - 1);
    check({tag, " busy in done"}, {31'd0, busy_o}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, " done single"}, {31'd0, done_o}, 32'd0);
    check({tag, " result held"}, result_o, m[31:0]);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    int          lat;
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result_o, 32'd0);
    check("reset outs", {29'd0, branch_taken_o, busy_o, done_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(4'd0, 32'd7, 32'd5, "ADD 7+5");
    run_op(4'd1, 32'd3, 32'd5, "SUB 3-5");
    run_op(4'd13, 32'h100, 32'h0, "JAL");
    run_op(4'd15, 32'h1234, 32'h5678, "op15");
    run_op(4'd9, 32'h1234, 32'h5678, "op9");
    run_op(4'd7, 32'd1, 32'd31, "SLL 31");
    run_op(4'd6, 32'h80000000, 32'h24, "SRL amt4");
    run_op(4'd6, 32'hdeadbeef, 32'h20, "SRL amt0");
    run_op(4'd11, 32'hffffffff, 32'd1, "BLT");
    run_op(4'd12, 32'hffffffff, 32'd1, "BGE");
    run_op(4'd8, 32'd5, 32'd5, "BEQ");
    run_op(4'd10, 32'd5, 32'd5, "BNE");
    run_op(4'd5, 32'd9, 32'habcd0000, "LUI");

    // ADD pulsed mid-shift is dropped; ADD in the done cycle is accepted
    @(negedge clk);
    start_i = 1'b1; ALU_Operation_i = 4'd7; A_i = 32'd1; B_i = 32'd31;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 100) begin
      if (lat == 5) begin
        start_i = 1'b1; ALU_Operation_i = 4'd0; A_i = 32'd100; B_i = 32'd200;
      end else start_i = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check("busy-ignore latency", lat, 32);
    check("busy-ignore result", result_o, 32'h80000000);
    start_i = 1'b1; ALU_Operation_i = 4'd0; A_i = 32'd10; B_i = 32'd20;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    check("b2b done", {31'd0, done_o}, 32'd1);
    check("b2b result", result_o, 32'd30);

    // async reset mid-shift
    @(negedge clk);
    start_i = 1'b1; ALU_Operation_i = 4'd7; A_i = 32'd1; B_i = 32'd31;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("pre-reset busy", {31'd0, busy_o}, 32'd1);
    reset = 1'b0;
    #1;
    check("async reset result", result_o, 32'd0);
    check("async reset outs", {29'd0, branch_taken_o, busy_o, done_o}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset hold done", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
      check("no stale done", {30'd0, done_o, busy_o}, 32'd0);
    end
    run_op(4'd0, 32'd1, 32'd1, "ADD after reset");

    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(15));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) b = a;
      run_op(op, a, b, $sformatf("rand%0d op%0d", i, op));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
